timer_countdown: RTL and testbench

Countdown datapath for the egg timer, directly downstream of the switch/KEY controller FSM and upstream of the 7-segment display stage. It takes the controller's 3-bit state code and the 8 switches, captures MM:SS as packed BCD, and counts down once per second while in TIMER. It flags expiry back to the controller and supplies a half-period flash tick for the FLASH_ON/FLASH_OFF alternation.

---
 rtl/timer_countdown_pkg.sv | 23 ++
 rtl/timer_countdown_digit.sv | 41 ++++
 rtl/timer_countdown.sv | 143 ++++++++++++++
 tb/tb_timer_countdown.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/timer_countdown_pkg.sv
// Shared definitions for the egg timer: controller state codes and BCD digit limits.
// Used by the controller, countdown datapath and display stages.
package timer_countdown_pkg;

    typedef enum logic [2:0] {
        ST_SET_SEC     = 3'b000,
        ST_SET_MIN     = 3'b001,
        ST_TIMER       = 3'b010,
        ST_READY       = 3'b011,
        ST_RESET       = 3'b100,
        ST_FLASH_ON    = 3'b101,
        ST_FLASH_OFF   = 3'b110,
        ST_SETTING_MIN = 3'b111
    } state_e;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_val);
        return (d > max_val) ? max_val : d;
    endfunction

endpackage

// File: rtl/timer_countdown_digit.sv
// One BCD digit of the countdown: loadable, decrements on an incoming borrow and
// wraps 0 -> MAX while requesting a borrow from the next digit up.
module bcd_digit_down
    import timer_countdown_pkg::*;
#(
    parameter logic [3:0] MAX = DIGIT_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    input  logic       borrow_in,
    output logic       borrow_out,
    output logic [3:0] digit
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = load_val;
        end else if (dec && borrow_in) begin
            digit_d = (digit_q == 4'd0) ? MAX : digit_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign borrow_out = dec && borrow_in && (digit_q == 4'd0);
    assign digit      = digit_q;

endmodule

// File: rtl/timer_countdown.sv
// Egg-timer countdown datapath: captures MM:SS from the switches, counts down once
// per second in TIMER, flags expiry and provides the flash-phase tick.
module timer_countdown
    import timer_countdown_pkg::*;
#(
    parameter int TICK_DIV  = 50000000,
    parameter int FLASH_DIV = 25000000
) (
    input  logic       CLOCK_50,
    input  logic       RESETN,
    input  logic [2:0] state,
    input  logic [7:0] SW,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       tick,
    output logic       expired,
    output logic       flash_tick
);

    localparam int TICK_W  = (TICK_DIV > 1)  ? $clog2(TICK_DIV)  : 1;
    localparam int FLASH_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_DIV - 1);

    state_e st;
    assign st = state_e'(state);

    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
    logic               tick_q, tick_d;
    logic               flash_tick_q, flash_tick_d;
    logic               expired_q, expired_d;

    // Digit order in the packed vectors: [0]=sec ones, [1]=sec tens, [2]=min ones, [3]=min tens.
    logic [3:0]  digit_load;
    logic [15:0] digit_load_val;
    logic [15:0] digits;
    logic [4:0]  borrow;
    logic        borrow_unused;
    logic        dec_en;
    logic        count_zero;
    logic        count_one;

    assign count_zero    = (digits == 16'h0000);
    assign count_one     = (digits == 16'h0001);
    assign borrow[0]     = 1'b1;
    assign borrow_unused = borrow[4];

    always_comb begin
        tick_cnt_d     = '0;
        flash_cnt_d    = '0;
        tick_d         = 1'b0;
        flash_tick_d   = 1'b0;
        expired_d      = expired_q;
        digit_load     = 4'b0000;
        digit_load_val = 16'h0000;
        dec_en         = 1'b0;
        case (st)
            ST_RESET: begin
                digit_load = 4'b1111;
                expired_d  = 1'b0;
            end
            ST_SET_SEC: begin
                digit_load           = 4'b0011;
                digit_load_val[7:4]  = clamp_digit(SW[7:4], SEC_TENS_MAX);
                digit_load_val[3:0]  = clamp_digit(SW[3:0], DIGIT_MAX);
                expired_d            = 1'b0;
            end
            ST_SET_MIN, ST_SETTING_MIN: begin
                digit_load            = 4'b1100;
                digit_load_val[15:12] = clamp_digit(SW[7:4], DIGIT_MAX);
                digit_load_val[11:8]  = clamp_digit(SW[3:0], DIGIT_MAX);
                expired_d             = 1'b0;
            end
            ST_READY: begin
            end
            ST_TIMER: begin
                if (tick_cnt_q == TICK_LAST) begin
                    tick_d = 1'b1;
                    // Decrement only from a live non-zero count, so 00:00 never wraps to 99:59.
                    if (!expired_q && !count_zero) begin
                        dec_en = 1'b1;
                        if (count_one) begin
                            expired_d = 1'b1;
                        end
                    end else begin
                        expired_d = 1'b1;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + TICK_W'(1);
                end
            end
            ST_FLASH_ON, ST_FLASH_OFF: begin
                if (flash_cnt_q == FLASH_LAST) begin
                    flash_tick_d = 1'b1;
                end else begin
                    flash_cnt_d = flash_cnt_q + FLASH_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESETN) begin
        if (!RESETN) begin
            tick_cnt_q   <= '0;
            flash_cnt_q  <= '0;
            tick_q       <= 1'b0;
            flash_tick_q <= 1'b0;
            expired_q    <= 1'b0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            flash_cnt_q  <= flash_cnt_d;
            tick_q       <= tick_d;
            flash_tick_q <= flash_tick_d;
            expired_q    <= expired_d;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        localparam logic [3:0] MAX = (gi == 1) ? SEC_TENS_MAX : DIGIT_MAX;
        bcd_digit_down #(
            .MAX(MAX)
        ) u_digit (
            .clk       (CLOCK_50),
            .rst_n     (RESETN),
            .load      (digit_load[gi]),
            .load_val  (digit_load_val[gi*4 +: 4]),
            .dec       (dec_en),
            .borrow_in (borrow[gi]),
            .borrow_out(borrow[gi+1]),
            .digit     (digits[gi*4 +: 4])
        );
    end

    assign min_bcd    = digits[15:8];
    assign sec_bcd    = digits[7:0];
    assign tick       = tick_q;
    assign expired    = expired_q;
    assign flash_tick = flash_tick_q;

endmodule

// File: tb/tb_timer_countdown.sv
// Directed bench for timer_countdown with small dividers; expected outputs are queued
// as each step is driven and compared on the following falling edge.
module tb_timer_countdown;
    import timer_countdown_pkg::*;

    localparam int TICK_DIV  = 4;
    localparam int FLASH_DIV = 3;

    logic       clk;
    logic       rst_n;
    logic [2:0] state;
    logic [7:0] sw;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       tick;
    logic       expired;
    logic       flash_tick;

    typedef struct {
        string       tag;
        logic [18:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    timer_countdown #(
        .TICK_DIV (TICK_DIV),
        .FLASH_DIV(FLASH_DIV)
    ) dut (
        .CLOCK_50  (clk),
        .RESETN    (rst_n),
        .state     (state),
        .SW        (sw),
        .min_bcd   (min_bcd),
        .sec_bcd   (sec_bcd),
        .tick      (tick),
        .expired   (expired),
        .flash_tick(flash_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_pop();
        exp_t        e;
        logic [18:0] obs;
        e   = sb_q.pop_front();
        obs = {min_bcd, sec_bcd, tick, expired, flash_tick};
        checks++;
        assert (obs === e.val)
        else begin
            errors++;
            $error("FAIL %s observed min=%h sec=%h tick=%b exp=%b flash=%b expected min=%h sec=%h tick=%b exp=%b flash=%b",
                   e.tag, obs[18:11], obs[10:3], obs[2], obs[1], obs[0],
                   e.val[18:11], e.val[10:3], e.val[2], e.val[1], e.val[0]);
        end
        $display("step %-14s min=%h sec=%h tick=%b exp=%b flash=%b", e.tag, min_bcd, sec_bcd, tick, expired, flash_tick);
    endtask

    task automatic push_exp(input string tag, input logic [7:0] emin, input logic [7:0] esec,
                            input logic et, input logic ee, input logic ef);
        sb_q.push_back('{tag, {emin, esec, et, ee, ef}});
    endtask

    task automatic check_now(input string tag, input logic [7:0] emin, input logic [7:0] esec,
                             input logic et, input logic ee, input logic ef);
        push_exp(tag, emin, esec, et, ee, ef);
        check_pop();
    endtask

    task automatic step(input logic [2:0] st, input logic [7:0] s);
        state = st;
        sw    = s;
        @(negedge clk);
    endtask

    task automatic stepx(input logic [2:0] st, input logic [7:0] s, input string tag,
                         input logic [7:0] emin, input logic [7:0] esec,
                         input logic et, input logic ee, input logic ef);
        state = st;
        sw    = s;
        push_exp(tag, emin, esec, et, ee, ef);
        @(negedge clk);
        check_pop();
    endtask

    // One full second in TIMER from a fresh prescaler: TICK_DIV-1 quiet cycles, then the tick.
    task automatic timer_second(input string tag, input logic [7:0] pmin, input logic [7:0] psec,
                                input logic pe, input logic [7:0] nmin, input logic [7:0] nsec,
                                input logic ne);
        for (int i = 0; i < TICK_DIV - 1; i++) begin
            stepx(ST_TIMER, 8'h00, {tag, "_wait"}, pmin, psec, 1'b0, pe, 1'b0);
        end
        stepx(ST_TIMER, 8'h00, tag, nmin, nsec, 1'b1, ne, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        state = ST_RESET;
        sw    = 8'h00;
        @(negedge clk);
        check_now("rst_init", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Switch capture and clamping
        stepx(ST_SET_SEC,     8'h45, "set_sec_45",  8'h00, 8'h45, 1'b0, 1'b0, 1'b0);
        stepx(ST_SET_SEC,     8'h7C, "sec_clamp",   8'h00, 8'h59, 1'b0, 1'b0, 1'b0);
        stepx(ST_SET_MIN,     8'hAF, "min_clamp",   8'h99, 8'h59, 1'b0, 1'b0, 1'b0);
        stepx(ST_SETTING_MIN, 8'h3B, "setting_min", 8'h39, 8'h59, 1'b0, 1'b0, 1'b0);
        stepx(ST_READY,       8'h12, "ready_hold",  8'h39, 8'h59, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle while counting, with tick high
        step(ST_SET_MIN, 8'h12);
        step(ST_SET_SEC, 8'h34);
        timer_second("t1_run", 8'h12, 8'h34, 1'b0, 8'h12, 8'h33, 1'b0);
        #2;
        rst_n = 1'b0;
        state = ST_RESET;
        #1;
        check_now("async_rst", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);

        // Minute borrows
        step(ST_SET_MIN, 8'h01);
        step(ST_SET_SEC, 8'h00);
        timer_second("t3_0100", 8'h01, 8'h00, 1'b0, 8'h00, 8'h59, 1'b0);
        step(ST_SET_MIN, 8'h10);
        step(ST_SET_SEC, 8'h00);
        timer_second("t3_1000", 8'h10, 8'h00, 1'b0, 8'h09, 8'h59, 1'b0);
        stepx(ST_READY, 8'h00, "t3_after", 8'h09, 8'h59, 1'b0, 1'b0, 1'b0);

        // Expiry and hold at 00:00
        step(ST_SET_MIN, 8'h00);
        step(ST_SET_SEC, 8'h02);
        timer_second("t4_tick1", 8'h00, 8'h02, 1'b0, 8'h00, 8'h01, 1'b0);
        timer_second("t4_tick2", 8'h00, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1);
        for (int k = 0; k < 8; k++) begin
            timer_second("t4_hold", 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b1);
        end

        // Flash prescaler runs across FLASH_ON/FLASH_OFF, then RESET clears everything
        for (int k = 0; k < 9; k++) begin
            stepx((k >= 3 && k < 6) ? ST_FLASH_OFF : ST_FLASH_ON, 8'h00, "t6_flash",
                  8'h00, 8'h00, 1'b0, 1'b1, (k % 3) == 2);
        end
        stepx(ST_RESET, 8'h00, "t6_reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            stepx(ST_RESET, 8'h00, "t6_quiet", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        end

        // Pause mid-second restarts the prescaler
        step(ST_SET_MIN, 8'h00);
        step(ST_SET_SEC, 8'h05);
        step(ST_TIMER, 8'h00);
        step(ST_TIMER, 8'h00);
        for (int k = 0; k < 9; k++) begin
            step(ST_READY, 8'h00);
        end
        stepx(ST_READY, 8'h00, "t5_paused", 8'h00, 8'h05, 1'b0, 1'b0, 1'b0);
        timer_second("t5_resume", 8'h00, 8'h05, 1'b0, 8'h00, 8'h04, 1'b0);

        // Prescaler wrap on the same cycle the state leaves TIMER
        for (int k = 0; k < TICK_DIV - 1; k++) begin
            step(ST_TIMER, 8'h00);
        end
        stepx(ST_READY, 8'h00, "wrap_exit", 8'h00, 8'h04, 1'b0, 1'b0, 1'b0);
        timer_second("after_exit", 8'h00, 8'h04, 1'b0, 8'h00, 8'h03, 1'b0);

        checks++;
        assert (sb_q.size() == 0)
        else begin
            errors++;
            $error("FAIL sb_drain observed %0d expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
